// File: rtl/scene_pkg.sv
// Shared types and constants for the display-scene controller: top/expression
// state encodings, the fixed pixel-source index map and the menu cursor codes.
package scene_pkg;

    typedef enum logic [2:0] {
        ST_EXPRESSION = 3'd0,
        ST_MENU       = 3'd1,
        ST_SETTING    = 3'd2,
        ST_GAME       = 3'd3,
        ST_POTATO     = 3'd4,
        ST_FINISH     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        EX_IDLE    = 3'd0,
        EX_HAPPY   = 3'd1,
        EX_SATISFY = 3'd2,
        EX_SLEEP   = 3'd3,
        EX_EXPECT  = 3'd4
    } express_t;

    localparam int SRC_IDLE    = 0;
    localparam int SRC_HAPPY   = 1;
    localparam int SRC_SATISFY = 2;
    localparam int SRC_SLEEP   = 3;
    localparam int SRC_EXPECT  = 4;
    localparam int SRC_MENU    = 5;
    localparam int SRC_POTATO  = 6;
    localparam int SRC_FILL    = 7;

    localparam logic [1:0] MENU_GAME     = 2'd0;
    localparam logic [1:0] MENU_POTATO   = 2'd1;
    localparam logic [1:0] MENU_SETTING  = 2'd2;
    localparam logic [1:0] MENU_RESERVED = 2'd3;

    // Source that should be on screen for a given top/expression state pair.
    function automatic int scene_target(input state_t st, input express_t ex);
        int src;
        src = SRC_IDLE;
        case (st)
            ST_EXPRESSION: begin
                case (ex)
                    EX_IDLE:    src = SRC_IDLE;
                    EX_HAPPY:   src = SRC_HAPPY;
                    EX_SATISFY: src = SRC_SATISFY;
                    EX_SLEEP:   src = SRC_SLEEP;
                    EX_EXPECT:  src = SRC_EXPECT;
                    default:    src = SRC_IDLE;
                endcase
            end
            ST_MENU:             src = SRC_MENU;
            ST_POTATO:           src = SRC_POTATO;
            ST_SETTING, ST_GAME: src = SRC_FILL;
            ST_FINISH:           src = SRC_HAPPY;
            default:             src = SRC_IDLE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/scene_sequencer_tick_timer.sv
// Saturating tick counter: advances on tick while enabled, clear wins over
// counting, done once TIMEOUT ticks have been seen.
module tick_timer #(
    parameter int TIMEOUT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic done
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && tick && (count_reg < SAT)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign done = (count_reg >= SAT);

endmodule

// File: rtl/scene_sequencer.sv
// Top-level UI state machine plus expression sub-machine; picks which pixel
// source feeds the LCD and swaps sources only at frame boundaries when asked.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int PIX_W        = 16,
    parameter int N_SRC        = 8,
    parameter int TICK_DIV     = 100_000_000,
    parameter int IDLE_TIMEOUT = 10,
    parameter int MENU_TIMEOUT = 10,
    parameter int FRAME_SYNC   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic [N_SRC*PIX_W-1:0]     src_data,
    input  logic                       go,
    input  logic                       pressed,
    input  logic                       touched,
    input  logic                       expecting,
    input  logic                       petting,
    input  logic                       awaking,
    input  logic                       left,
    input  logic                       right,
    input  logic [1:0]                 menu_mode,
    input  logic                       potato_finish,
    output logic [PIX_W-1:0]           pix_out,
    output logic [$clog2(N_SRC)-1:0]   disp_sel,
    output logic [2:0]                 state_o,
    output logic [2:0]                 express_o,
    output logic                       potato_start
);
    localparam int SEL_W = $clog2(N_SRC);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ---------------------------------------------------------------
    // Shared tick prescaler
    // ---------------------------------------------------------------
    logic [PRE_W-1:0] presc_reg;
    logic             tick;

    assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Inactivity timers
    // ---------------------------------------------------------------
    state_t   state_reg, state_next;
    express_t express_reg, express_next;
    logic     idle_active, idle_clear, idle_done;
    logic     menu_active, menu_clear, menu_done;

    assign idle_active = (state_reg == ST_EXPRESSION) && (express_reg == EX_IDLE);
    assign idle_clear  = !idle_active || go || touched || pressed;

    // Any state transition restarts the menu timer, so entry always begins at 0.
    assign menu_active = (state_reg == ST_MENU) || (state_reg == ST_FINISH);
    assign menu_clear  = left || right || pressed || (state_next != state_reg);

    tick_timer #(.TIMEOUT(IDLE_TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (idle_active),
        .clear  (idle_clear),
        .tick   (tick),
        .done   (idle_done)
    );

    tick_timer #(.TIMEOUT(MENU_TIMEOUT)) u_menu_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (menu_active),
        .clear  (menu_clear),
        .tick   (tick),
        .done   (menu_done)
    );

    // ---------------------------------------------------------------
    // Transition decisions for both machines, evaluated on the same cycle
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EXPRESSION: if (pressed) state_next = ST_MENU;
            ST_MENU: begin
                if (menu_done) begin
                    state_next = ST_EXPRESSION;
                end else if (pressed) begin
                    case (menu_mode)
                        MENU_GAME:    state_next = ST_GAME;
                        MENU_POTATO:  state_next = ST_POTATO;
                        MENU_SETTING: state_next = ST_SETTING;
                        default:      state_next = ST_MENU;
                    endcase
                end
            end
            ST_SETTING, ST_GAME: if (pressed) state_next = ST_MENU;
            ST_POTATO:     if (potato_finish) state_next = ST_FINISH;
            ST_FINISH:     if (menu_done) state_next = ST_MENU;
            default:       state_next = ST_EXPRESSION;
        endcase
    end

    always_comb begin
        express_next = express_reg;
        if (state_reg == ST_EXPRESSION) begin
            case (express_reg)
                EX_IDLE: begin
                    if (idle_done)           express_next = EX_SLEEP;
                    else if (expecting)      express_next = EX_EXPECT;
                    else if (touched || go)  express_next = EX_HAPPY;
                end
                EX_HAPPY:   if (go || !touched) express_next = EX_IDLE;
                EX_SATISFY: if (!petting)       express_next = EX_EXPECT;
                EX_SLEEP:   if (awaking)        express_next = EX_IDLE;
                EX_EXPECT: begin
                    if (!expecting || pressed) express_next = EX_IDLE;
                    else if (petting)          express_next = EX_SATISFY;
                end
                default: express_next = EX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_EXPRESSION;
            express_reg <= EX_IDLE;
        end else begin
            state_reg   <= state_next;
            express_reg <= express_next;
        end
    end

    // ---------------------------------------------------------------
    // Source selection and pixel path
    // ---------------------------------------------------------------
    logic [PIX_W-1:0] src_arr [N_SRC];
    logic [SEL_W-1:0] target_sel;
    logic [SEL_W-1:0] disp_sel_reg;
    logic [PIX_W-1:0] pix_reg;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_arr[gi] = src_data[gi*PIX_W +: PIX_W];
    end

    // Target comes from the registered state, so a frame_start on the same
    // cycle as a transition still latches the outgoing scene.
    assign target_sel = SEL_W'(scene_target(state_reg, express_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sel_reg <= '0;
            pix_reg      <= '0;
        end else begin
            if ((FRAME_SYNC == 0) || frame_start) begin
                disp_sel_reg <= target_sel;
            end
            pix_reg <= src_arr[disp_sel_reg];
        end
    end

    assign pix_out      = pix_reg;
    assign disp_sel     = disp_sel_reg;
    assign state_o      = state_reg;
    assign express_o    = express_reg;
    assign potato_start = (state_reg == ST_POTATO);

endmodule
